// File: rtl/jk_excite_driver.sv
// rtl/jk_excite_driver.sv - J/K excitation driver with readback verify, retry and sticky fault (optional stats: JKDRV_STATS_EN)
module jk_excite_driver #(
  parameter int WIDTH     = 8,
  parameter int MODE      = 0,
  parameter int MAX_RETRY = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [WIDTH-1:0]     q_fb,
  output logic [WIDTH-1:0]     j,
  output logic [WIDTH-1:0]     k,
  output logic                 done,
  output logic                 err,
  output logic                 fault,
  input  logic                 clear_fault,
  output logic [ERR_CNT_W-1:0] err_cnt
`ifdef JKDRV_STATS_EN
  ,
  output logic [15:0]          done_cnt,
  output logic [WIDTH-1:0]     last_toggled
`endif
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, FAULT} state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] target_r;
  logic [3:0]       retry_cnt;
  logic [WIDTH-1:0] diff;
  logic             match;
  logic             retry_left;

  // Bits that still differ between the bank and the requested word
  assign diff       = target_r ^ q_fb;
  assign match      = (diff == '0);
  assign retry_left = (retry_cnt < 4'(MAX_RETRY));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and outputs; done/err are masked while reset is asserted so an aborted check emits nothing
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    j        = '0;
    k        = '0;
    done     = 1'b0;
    err      = 1'b0;
    fault    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = DRIVE;
      end
      DRIVE: begin
        // Only differing bits are excited; matching bits hold with j=k=0
        if (MODE == 0) begin
          j = target_r & diff;
          k = ~target_r & diff;
        end else begin
          j = diff;
          k = diff;
        end
        state_nx = CHECK;
      end
      CHECK: begin
        if (match) begin
          done     = rst_n;
          state_nx = IDLE;
        end else begin
          err      = rst_n;
          state_nx = retry_left ? DRIVE : FAULT;
        end
      end
      FAULT: begin
        fault = 1'b1;
        if (clear_fault) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Captured target, retry counter and saturating mismatch counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      target_r  <= '0;
      retry_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        target_r  <= in_data;
        retry_cnt <= '0;
      end
      if (state == CHECK && !match) begin
        if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
        if (retry_left)    retry_cnt <= retry_cnt + 4'd1;
      end
    end
  end

`ifdef JKDRV_STATS_EN
  // Completed-write counter (wraps) and the bit set the first drive of each write had to change
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_cnt     <= '0;
      last_toggled <= '0;
    end else begin
      if (state == CHECK && match)            done_cnt     <= done_cnt + 16'd1;
      if (state == DRIVE && retry_cnt == 4'd0) last_toggled <= diff;
    end
  end
`endif

endmodule

// File: tb/tb_jk_excite_driver.sv
// tb/tb_jk_excite_driver.sv - scoreboard bench for jk_excite_driver (set/reset and toggle instances in lockstep)
module tb_jk_excite_driver;

  localparam int MR = 2;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, in_valid, clear_fault;
  logic [7:0] in_data;
  logic       in_ready0, in_ready1, done0, done1, err0, err1, fault0, fault1;
  logic [7:0] j0, k0, j1, k1, q0, q1;
  logic [7:0] ec0;
  logic [1:0] ec1;
  logic       bank_load;
  logic [7:0] bank_val, stuck;
`ifdef JKDRV_STATS_EN
  logic [15:0] dc0, dc1;
  logic [7:0]  lt0, lt1;
`endif

  jk_excite_driver #(.WIDTH(8), .MODE(0), .MAX_RETRY(MR), .ERR_CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .q_fb(q0), .j(j0), .k(k0), .done(done0), .err(err0), .fault(fault0),
    .clear_fault(clear_fault), .err_cnt(ec0)
`ifdef JKDRV_STATS_EN
    , .done_cnt(dc0), .last_toggled(lt0)
`endif
  );

  jk_excite_driver #(.WIDTH(8), .MODE(1), .MAX_RETRY(MR), .ERR_CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .q_fb(q1), .j(j1), .k(k1), .done(done1), .err(err1), .fault(fault1),
    .clear_fault(clear_fault), .err_cnt(ec1)
`ifdef JKDRV_STATS_EN
    , .done_cnt(dc1), .last_toggled(lt1)
`endif
  );

  // JK flop banks, with optional stuck-at-0 bits
  always @(posedge clk) begin
    if (bank_load) begin
      q0 <= bank_val & ~stuck;
      q1 <= bank_val & ~stuck;
    end else begin
      q0 <= ((j0 & ~q0) | (~k0 & q0)) & ~stuck;
      q1 <= ((j1 & ~q1) | (~k1 & q1)) & ~stuck;
    end
  end

  typedef struct {
    bit         is_done;
    int         attempt;
    logic [7:0] ej0, ek0, ej1, ek1;
    logic [7:0] ec0;
    logic [1:0] ec1;
  } exp_t;

  exp_t       sbq[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         hs_cyc = 0;
  logic [7:0] pj0, pk0, pj1, pk1;

  logic [7:0] mq;
  int         merr0, merr1;
  bit         mfault;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Reference: each attempt leaves the bank at target with stuck bits forced low
  function automatic void model_write(input logic [7:0] t);
    exp_t e;
    logic [7:0] d;
    for (int a = 0; a <= MR; a++) begin
      d         = mq ^ t;
      e.attempt = a;
      e.ej0     = t & d;
      e.ek0     = ~t & d;
      e.ej1     = d;
      e.ek1     = d;
      e.ec0     = 8'(merr0);
      e.ec1     = 2'(merr1);
      mq        = t & ~stuck;
      e.is_done = (mq == t);
      sbq.push_back(e);
      if (e.is_done) begin
        mfault = 0;
        return;
      end
      merr0 = (merr0 < 255) ? merr0 + 1 : 255;
      merr1 = (merr1 < 3) ? merr1 + 1 : 3;
    end
    mfault = 1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops an expectation whenever a done/err pulse is seen
  always @(negedge clk) begin
    exp_t e;
    if (in_valid && in_ready0) hs_cyc = cyc;
    if (done0 || err0 || done1 || err1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event actual=%0b%0b required=none", done0, err0);
      end else begin
        e = sbq.pop_front();
        chk("kind0", {30'd0, done0, err0}, e.is_done ? 32'd2 : 32'd1);
        chk("kind1", {30'd0, done1, err1}, e.is_done ? 32'd2 : 32'd1);
        chk("latency", 32'(cyc - hs_cyc), 32'(2 + 2 * e.attempt));
        chk("drive_j0", {24'd0, pj0}, {24'd0, e.ej0});
        chk("drive_k0", {24'd0, pk0}, {24'd0, e.ek0});
        chk("drive_j1", {24'd0, pj1}, {24'd0, e.ej1});
        chk("drive_k1", {24'd0, pk1}, {24'd0, e.ek1});
        chk("err_cnt0_at_check", {24'd0, ec0}, {24'd0, e.ec0});
        chk("err_cnt1_at_check", {30'd0, ec1}, {30'd0, e.ec1});
      end
    end
    pj0 = j0; pk0 = k0; pj1 = j1; pk1 = k1;
  end

  task automatic preload(input logic [7:0] v);
    @(posedge clk); #1;
    bank_load = 1'b1;
    bank_val  = v;
    @(posedge clk); #1;
    bank_load = 1'b0;
    mq        = v & ~stuck;
  endtask

  task automatic set_stuck(input logic [7:0] s);
    @(posedge clk); #1;
    stuck = s;
    @(posedge clk); #1;
    mq = mq & ~s;
  endtask

  task automatic do_write(input logic [7:0] t);
    int n;
    bit exp_f;
    model_write(t);
    exp_f = mfault;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = t;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("busy_after_hs", {31'd0, in_ready0}, 32'd0);
    n = 0;
    while (!(in_ready0 || fault0) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL write_timeout actual=%0d required=<40", n);
    end
    chk("fault0", {31'd0, fault0}, {31'd0, exp_f});
    chk("fault1", {31'd0, fault1}, {31'd0, exp_f});
    chk("in_ready0", {31'd0, in_ready0}, {31'd0, !exp_f});
    chk("err_cnt0", {24'd0, ec0}, 32'(merr0));
    chk("err_cnt1", {30'd0, ec1}, 32'(merr1));
    chk("idle_jk", {16'd0, j0, k0}, 32'd0);
    if (exp_f) begin
      clear_fault = 1'b1;
      @(posedge clk); #1;
      clear_fault = 1'b0;
      chk("clear_ready", {31'd0, in_ready0}, 32'd1);
      chk("clear_fault", {31'd0, fault0}, 32'd0);
      chk("clear_keep_cnt", {24'd0, ec0}, 32'(merr0));
    end
  endtask

  initial begin
    logic [7:0] t;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    clear_fault = 1'b0;
    stuck       = 8'h00;
    bank_load   = 1'b1;
    bank_val    = 8'h00;
    mq          = 8'h00;
    merr0       = 0;
    merr1       = 0;
    mfault      = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    bank_load = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready0}, 32'd1);
    chk("rst_fault", {30'd0, fault0, fault1}, 32'd0);
    chk("rst_done_err", {28'd0, done0, err0, done1, err1}, 32'd0);
    chk("rst_jk", {j0, k0, j1, k1}, 32'd0);
    chk("rst_err_cnt", {22'd0, ec0, ec1}, 32'd0);

    do_write(8'hA5);
    do_write(8'h5A);
    preload(8'h3C);
    do_write(8'h3C);
    set_stuck(8'h01);
    do_write(8'h01);
    do_write(8'h03);
    chk("err_cnt1_saturated", {30'd0, ec1}, 32'd3);
    set_stuck(8'h00);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(4) == 0) set_stuck(8'(1 << $urandom_range(7)));
      else if (stuck != 8'h00)    set_stuck(8'h00);
      if ($urandom_range(5) == 0) preload(8'($urandom));
      do_write(8'($urandom));
    end

    set_stuck(8'h80);
    t = 8'h80 | 8'($urandom);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = t;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_check_pulse", {28'd0, done0, err0, done1, err1}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mq    = t & ~stuck;
    merr0 = 0;
    merr1 = 0;
    chk("abort_in_ready", {31'd0, in_ready0}, 32'd1);
    chk("abort_fault", {30'd0, fault0, fault1}, 32'd0);
    chk("abort_err_cnt", {22'd0, ec0, ec1}, 32'd0);
    chk("abort_jk", {j0, k0, j1, k1}, 32'd0);
    set_stuck(8'h00);
    do_write(8'($urandom));

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
